// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared opcodes, sequencer state encoding and opcode
//               classification helpers for the ALU issue sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    // ALU opcodes understood by the sequencer
    localparam logic [4:0] OP_NOP  = 5'b00000;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ROR  = 5'b00111;
    localparam logic [4:0] OP_ROL  = 5'b01000;
    localparam logic [4:0] OP_SHR  = 5'b01001;
    localparam logic [4:0] OP_SHRA = 5'b01010;
    localparam logic [4:0] OP_SHL  = 5'b01011;
    localparam logic [4:0] OP_DIV  = 5'b01111;
    localparam logic [4:0] OP_MUL  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;

    // Sequencer states
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXEC    = 2'd1,
        ST_SEND_LO = 2'd2,
        ST_SEND_HI = 2'd3
    } state_t;

    // True for every opcode the sequencer will issue to the ALU
    function automatic logic is_legal(input logic [4:0] op);
        logic legal;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_ROR, OP_ROL, OP_SHR, OP_SHRA, OP_SHL,
            OP_NEG, OP_NOT, OP_MUL, OP_DIV: legal = 1'b1;
            default:                        legal = 1'b0;
        endcase
        return legal;
    endfunction

    // True for opcodes producing a meaningful 64-bit result
    function automatic logic is_wide(input logic [4:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_op_decode.sv
`default_nettype none
// ============================================================================
// Module      : alu_op_decode
// Description : Combinational opcode classifier (legal / wide result).
// Revision    : 1.0 - initial release
// ============================================================================
module alu_op_decode
    import alu_pkg::*;
(
    input  logic [4:0] i_op,
    output logic       o_legal,
    output logic       o_wide
);

    assign o_legal = is_legal(i_op);
    assign o_wide  = is_wide(i_op);

endmodule
`default_nettype wire

// File: rtl/alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : alu_sequencer
// Description : Issues one opcode/operand pair to the datapath ALU, holds it
//               for EXEC_CYCLES, captures the 64-bit result into ZLO/ZHI and
//               returns it as one (narrow) or two (MUL/DIV) ready/valid beats.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int EXEC_CYCLES = 1
) (
    input  logic        clock,
    input  logic        clear,
    input  logic        start,
    output logic        ready,
    input  logic [4:0]  op_in,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    output logic [4:0]  alu_opcode,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    input  logic [63:0] alu_z,
    output logic [31:0] zlo,
    output logic [31:0] zhi,
    output logic        res_valid,
    output logic [31:0] res_data,
    output logic        res_last,
    input  logic        res_ready,
    output logic        illegal
);

    // Counter only needs to reach EXEC_CYCLES-1
    localparam int               CNT_W    = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(EXEC_CYCLES - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [4:0]        r_op;
    logic [31:0]       r_a;
    logic [31:0]       r_b;
    logic              r_wide;
    logic [CNT_W-1:0]  r_cnt;
    logic [31:0]       r_zlo;
    logic [31:0]       r_zhi;
    logic              r_illegal;

    logic              w_legal;
    logic              w_wide;
    logic              w_accept;
    logic              w_exec_done;

    alu_op_decode u_decode (
        .i_op    (op_in),
        .o_legal (w_legal),
        .o_wide  (w_wide)
    );

    assign ready       = (r_state == ST_IDLE) && clear;
    assign w_accept    = start && ready;
    assign w_exec_done = (r_state == ST_EXEC) && (r_cnt == CNT_LAST);

    // State register
    always_ff @(posedge clock) begin
        if (!clear) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: illegal requests are consumed without leaving IDLE
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:    if (w_accept && w_legal) w_state_nxt = ST_EXEC;
            ST_EXEC:    if (w_exec_done)         w_state_nxt = ST_SEND_LO;
            ST_SEND_LO: if (res_ready)           w_state_nxt = r_wide ? ST_SEND_HI : ST_IDLE;
            ST_SEND_HI: if (res_ready)           w_state_nxt = ST_IDLE;
            default:                             w_state_nxt = ST_IDLE;
        endcase
    end

    // Request latch, exec counter, result capture and illegal pulse
    always_ff @(posedge clock) begin
        if (!clear) begin
            r_op      <= OP_NOP;
            r_a       <= 32'd0;
            r_b       <= 32'd0;
            r_wide    <= 1'b0;
            r_cnt     <= {CNT_W{1'b0}};
            r_zlo     <= 32'd0;
            r_zhi     <= 32'd0;
            r_illegal <= 1'b0;
        end else begin
            r_illegal <= w_accept && !w_legal;
            if (w_accept && w_legal) begin
                r_op   <= op_in;
                r_a    <= src_a;
                r_b    <= src_b;
                r_wide <= w_wide;
                r_cnt  <= {CNT_W{1'b0}};
            end else if (r_state == ST_EXEC) begin
                r_cnt <= r_cnt + 1'b1;
            end
            // Upper ALU word is undefined for narrow ops, so it is zeroed
            if (w_exec_done) begin
                r_zlo <= alu_z[31:0];
                r_zhi <= r_wide ? alu_z[63:32] : 32'd0;
            end
        end
    end

    // State-decoded ALU drive and result beat outputs
    always_comb begin
        alu_opcode = OP_NOP;
        res_valid  = 1'b0;
        res_data   = 32'd0;
        res_last   = 1'b0;
        case (r_state)
            ST_EXEC: begin
                alu_opcode = r_op;
            end
            ST_SEND_LO: begin
                res_valid = 1'b1;
                res_data  = r_zlo;
                res_last  = !r_wide;
            end
            ST_SEND_HI: begin
                res_valid = 1'b1;
                res_data  = r_zhi;
                res_last  = 1'b1;
            end
            default: begin
                alu_opcode = OP_NOP;
            end
        endcase
    end

    assign alu_a   = r_a;
    assign alu_b   = r_b;
    assign zlo     = r_zlo;
    assign zhi     = r_zhi;
    assign illegal = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_sequencer
// Description : Self-checking bench for alu_sequencer with a stub ALU.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_sequencer;

    localparam int EXEC = 2;

    localparam logic [4:0] ADD  = 5'b00011, SUB = 5'b00100, AND_ = 5'b00101;
    localparam logic [4:0] OR_  = 5'b00110, ROR = 5'b00111, ROL  = 5'b01000;
    localparam logic [4:0] SHR  = 5'b01001, SHRA = 5'b01010, SHL = 5'b01011;
    localparam logic [4:0] DIV  = 5'b01111, MUL = 5'b10000, NEG  = 5'b10001;
    localparam logic [4:0] NOT_ = 5'b10010;

    logic        clock = 1'b0;
    logic        clear, start, ready, res_valid, res_last, res_ready, illegal;
    logic [4:0]  op_in, alu_opcode;
    logic [31:0] src_a, src_b, alu_a, alu_b, zlo, zhi, res_data;
    logic [63:0] alu_z;

    int n_vec = 0;
    int n_err = 0;

    alu_sequencer #(.EXEC_CYCLES(EXEC)) dut (
        .clock      (clock),
        .clear      (clear),
        .start      (start),
        .ready      (ready),
        .op_in      (op_in),
        .src_a      (src_a),
        .src_b      (src_b),
        .alu_opcode (alu_opcode),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_z      (alu_z),
        .zlo        (zlo),
        .zhi        (zhi),
        .res_valid  (res_valid),
        .res_data   (res_data),
        .res_last   (res_last),
        .res_ready  (res_ready),
        .illegal    (illegal)
    );

    always #5 clock = ~clock;

    function automatic bit wide_op(input logic [4:0] op);
        return (op == MUL) || (op == DIV);
    endfunction

    // Arithmetic meaning of each opcode; DIV packs {remainder, quotient}
    function automatic logic [63:0] alu_math(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        logic [63:0] aa;
        int          sh;
        sh = int'(b[4:0]);
        aa = {a, a};
        case (op)
            ADD:  r = a + b;
            SUB:  r = a - b;
            AND_: r = a & b;
            OR_:  r = a | b;
            SHR:  r = a >> sh;
            SHRA: r = $signed(a) >>> sh;
            SHL:  r = a << sh;
            ROR:  r = aa[31:0] >> sh | (a << (32 - sh));
            ROL:  r = (a << sh) | (a >> (32 - sh));
            NEG:  r = 32'd0 - a;
            NOT_: r = ~a;
            MUL:  return {32'd0, a} * {32'd0, b};
            DIV:  return (b == 0) ? 64'd0 : {a % b, a / b};
            default: r = 32'd0;
        endcase
        return {32'd0, r};
    endfunction

    // Stub ALU: narrow ops leave garbage in the upper word
    always_comb begin
        alu_z = alu_math(alu_opcode, alu_a, alu_b);
        if (alu_opcode != 5'b00000 && !wide_op(alu_opcode))
            alu_z[63:32] = 32'hDEAD_BEEF;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Issue one request and drain its beats, checking timing and data
    task automatic run_txn(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                           input int stall, input logic [31:0] exp_lo, input logic [31:0] exp_hi,
                           input bit poke, input string tag);
        int  guard;
        bit  wide;
        logic [31:0] d;
        wide  = wide_op(op);
        guard = 0;
        while (!ready && guard < 20) begin
            step();
            guard++;
        end
        check({tag, " ready_before"}, ready, 1);
        if (!ready) return;
        start = 1'b1; op_in = op; src_a = a; src_b = b;
        step();
        start = 1'b0; src_a = ~a; src_b = ~b;
        for (int i = 1; i <= EXEC; i++) begin
            check({tag, " exec_valid"}, res_valid, 0);
            check({tag, " exec_ready"}, ready, 0);
            check({tag, " exec_opcode"}, alu_opcode, op);
            check({tag, " exec_a"}, alu_a, a);
            check({tag, " exec_b"}, alu_b, b);
            if (poke) begin
                start = 1'b1; op_in = OR_; src_a = 32'h1111_0000; src_b = 32'h55;
            end
            step();
            start = 1'b0;
        end
        for (int bt = 0; bt < (wide ? 2 : 1); bt++) begin
            d = (bt == 1) ? exp_hi : exp_lo;
            for (int s = 0; s <= stall; s++) begin
                res_ready = (s == stall);
                check({tag, " beat_valid"}, res_valid, 1);
                check({tag, " beat_data"}, res_data, d);
                check({tag, " beat_last"}, res_last, (!wide || bt == 1));
                check({tag, " beat_opcode"}, alu_opcode, 0);
                step();
            end
            res_ready = 1'b0;
        end
        check({tag, " done_valid"}, res_valid, 0);
        check({tag, " done_ready"}, ready, 1);
        check({tag, " zlo"}, zlo, exp_lo);
        check({tag, " zhi"}, zhi, exp_hi);
    endtask

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        int          stall;
        logic [31:0] lo;
        logic [31:0] hi;
    } vec_t;

    vec_t tbl[14];
    logic [4:0] legal_ops[13];
    logic [4:0] bad_ops[3];

    initial begin
        tbl[0]  = '{ADD,  32'd5,          32'd7,          0, 32'd12,         32'd0};
        tbl[1]  = '{MUL,  32'h0001_0000,  32'h0001_0000,  0, 32'd0,          32'd1};
        tbl[2]  = '{DIV,  32'd100,        32'd7,          3, 32'h0000_000E,  32'd2};
        tbl[3]  = '{SUB,  32'd10,         32'd3,          1, 32'd7,          32'd0};
        tbl[4]  = '{AND_, 32'hF0F0_FFFF,  32'h0FF0_00FF,  0, 32'h00F0_00FF,  32'd0};
        tbl[5]  = '{OR_,  32'hF000_0000,  32'h0000_000F,  2, 32'hF000_000F,  32'd0};
        tbl[6]  = '{SHR,  32'h8000_0000,  32'd4,          0, 32'h0800_0000,  32'd0};
        tbl[7]  = '{SHRA, 32'h8000_0000,  32'd4,          0, 32'hF800_0000,  32'd0};
        tbl[8]  = '{SHL,  32'h0000_0001,  32'd31,         0, 32'h8000_0000,  32'd0};
        tbl[9]  = '{ROR,  32'h0000_0001,  32'd1,          0, 32'h8000_0000,  32'd0};
        tbl[10] = '{ROL,  32'h8000_0001,  32'd4,          0, 32'h0000_0018,  32'd0};
        tbl[11] = '{NEG,  32'd1,          32'd0,          0, 32'hFFFF_FFFF,  32'd0};
        tbl[12] = '{NOT_, 32'h1234_5678,  32'd0,          1, 32'hEDCB_A987,  32'd0};
        tbl[13] = '{MUL,  32'hFFFF_FFFF,  32'd2,          2, 32'hFFFF_FFFE,  32'd1};
        legal_ops = '{ADD, SUB, AND_, OR_, ROR, ROL, SHR, SHRA, SHL, DIV, MUL, NEG, NOT_};
        bad_ops   = '{5'b11111, 5'b00000, 5'b01100};

        clear = 1'b0; start = 1'b0; res_ready = 1'b0;
        op_in = 5'd0; src_a = 32'd0; src_b = 32'd0;

        // Reset state
        repeat (3) step();
        check("rst_ready", ready, 0);
        check("rst_valid", res_valid, 0);
        check("rst_data", res_data, 0);
        check("rst_last", res_last, 0);
        check("rst_illegal", illegal, 0);
        check("rst_zlo", zlo, 0);
        check("rst_zhi", zhi, 0);
        check("rst_opcode", alu_opcode, 0);
        check("rst_a", alu_a, 0);
        check("rst_b", alu_b, 0);
        clear = 1'b1;
        step();
        check("rst_ready_release", ready, 1);

        // Directed table
        for (int i = 0; i < 14; i++)
            run_txn(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].stall, tbl[i].lo, tbl[i].hi, 1'b0,
                    $sformatf("tbl%0d", i));

        // Illegal opcodes: single-cycle pulse, no beat, stays ready
        for (int i = 0; i < 3; i++) begin
            start = 1'b1; op_in = bad_ops[i]; src_a = 32'd9; src_b = 32'd9;
            step();
            start = 1'b0;
            check("ill_pulse", illegal, 1);
            check("ill_valid", res_valid, 0);
            check("ill_ready", ready, 1);
            step();
            check("ill_pulse_end", illegal, 0);
            check("ill_valid2", res_valid, 0);
            check("ill_ready2", ready, 1);
        end

        // Start during EXEC is ignored, then back-to-back SUB
        run_txn(ADD, 32'd5, 32'd7, 0, 32'd12, 32'd0, 1'b1, "poke_add");
        run_txn(SUB, 32'd10, 32'd3, 0, 32'd7, 32'd0, 1'b0, "b2b_sub");

        // Reset while the MUL high beat is pending
        start = 1'b1; op_in = MUL; src_a = 32'h0001_0000; src_b = 32'h0001_0000;
        step();
        start = 1'b0;
        repeat (EXEC) step();
        check("rmid_lo_data", res_data, 0);
        check("rmid_lo_last", res_last, 0);
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        check("rmid_hi_valid", res_valid, 1);
        check("rmid_hi_data", res_data, 1);
        clear = 1'b0;
        step();
        check("rmid_valid", res_valid, 0);
        check("rmid_zlo", zlo, 0);
        check("rmid_zhi", zhi, 0);
        check("rmid_ready_low", ready, 0);
        clear = 1'b1;
        #1;
        check("rmid_ready_back", ready, 1);
        step();
        check("rmid_no_beat", res_valid, 0);

        // Randomized requests against the arithmetic model
        for (int i = 0; i < 40; i++) begin
            logic [4:0]  op;
            logic [31:0] a, b;
            logic [63:0] r;
            op = legal_ops[$urandom_range(0, 12)];
            a  = $urandom;
            b  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            r  = alu_math(op, a, b);
            run_txn(op, a, b, $urandom_range(0, 2), r[31:0], wide_op(op) ? r[63:32] : 32'd0,
                    1'($urandom_range(0, 1)), $sformatf("rnd%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
